// File: rtl/fft_bit_reverse_pkg.sv
// Shared FFT constants and helpers for the output reorder stage.
package fft_bit_reverse_pkg;

  localparam int FFT_N     = 1024;
  localparam int FFT_NLOG2 = 10;
  localparam int ADDR_W    = FFT_NLOG2 + 1;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_READ = 1'b1
  } rd_state_e;

  // Reverses the low nbits of idx; bits above nbits come back as zero.
  function automatic logic [31:0] bitrev(input logic [31:0] idx, input int nbits);
    logic [31:0] r;
    logic [31:0] v;
    r = '0;
    v = idx;
    for (int i = 0; i < 32; i++) begin
      if (i < nbits) begin
        r = {r[30:0], v[0]};
        v = v >> 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_bit_reverse_ram.sv
// Simple dual-port RAM, registered read, read-during-write returns old data.
module fft_bit_reverse_ram
  import fft_bit_reverse_pkg::*;
#(
  parameter int AW = ADDR_W,
  parameter int DW = 50
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fft_bit_reverse.sv
// Ping-pong reorder buffer: bit-reversed writes, natural-order readout, one bin per clock.
module fft_bit_reverse #(
  parameter int DATA_WIDTH = 25,
  parameter int FFT_N      = fft_bit_reverse_pkg::FFT_N,
  parameter int FFT_NLOG2  = fft_bit_reverse_pkg::FFT_NLOG2
) (
  input  logic                         clk_i,
  input  logic                         rst_n,
  input  logic                         valid_i,
  input  logic [FFT_NLOG2-1:0]         cnt_i,
  input  logic signed [DATA_WIDTH-1:0] x_re_i,
  input  logic signed [DATA_WIDTH-1:0] x_im_i,
  output logic                         valid_o,
  output logic [FFT_NLOG2-1:0]         cnt_o,
  output logic signed [DATA_WIDTH-1:0] z_re_o,
  output logic signed [DATA_WIDTH-1:0] z_im_o,
  output logic                         overrun_o
);
  import fft_bit_reverse_pkg::*;

  localparam int AW = FFT_NLOG2 + 1;
  localparam int DW = 2 * DATA_WIDTH;
  localparam logic [FFT_NLOG2-1:0] LAST = FFT_NLOG2'(FFT_N - 1);

  rd_state_e                 state_q, state_d;
  logic [FFT_NLOG2-1:0]      raddr_q, raddr_d;
  logic                      wbank_q, wbank_d;
  logic                      rbank_q, rbank_d;
  logic [1:0]                full_q, full_d;
  logic                      overrun_q, overrun_d;
  logic [1:0]                vld_pipe_q, vld_pipe_d;
  logic [FFT_NLOG2-1:0]      cnt_s1_q, cnt_s1_d;
  logic [FFT_NLOG2-1:0]      cnt_o_q, cnt_o_d;
  logic [DATA_WIDTH-1:0]     z_re_q, z_re_d;
  logic [DATA_WIDTH-1:0]     z_im_q, z_im_d;

  logic                      frame_done;
  logic                      rd_last;
  logic [FFT_NLOG2-1:0]      wr_idx;
  logic [AW-1:0]             ram_waddr;
  logic [AW-1:0]             ram_raddr;
  logic [DW-1:0]             ram_rdata;

  assign frame_done = valid_i && (cnt_i == LAST);
  assign rd_last    = (state_q == RD_READ) && (raddr_q == LAST);
  assign wr_idx     = FFT_NLOG2'(bitrev(32'(cnt_i), FFT_NLOG2));
  assign ram_waddr  = {wbank_q, wr_idx};
  assign ram_raddr  = {rbank_q, raddr_q};

  fft_bit_reverse_ram #(
    .AW (AW),
    .DW (DW)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (valid_i && rst_n),
    .waddr_i (ram_waddr),
    .wdata_i ({x_re_i, x_im_i}),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    state_d    = state_q;
    raddr_d    = raddr_q;
    wbank_d    = wbank_q ^ frame_done;
    rbank_d    = rbank_q;
    full_d     = full_q;
    overrun_d  = overrun_q;

    if (rd_last) begin
      full_d[rbank_q] = 1'b0;
      rbank_d         = ~rbank_q;
    end
    // Landing on the bank whose final address is being read this edge is not an overrun.
    if (frame_done) begin
      full_d[wbank_q] = 1'b1;
      if (full_q[~wbank_q] && !(rd_last && (rbank_q == ~wbank_q))) overrun_d = 1'b1;
    end

    // Start on the completion edge itself so bin 0 lands two edges later.
    case (state_q)
      RD_IDLE: begin
        if ((full_q != 2'b00) || frame_done) begin
          state_d = RD_READ;
          raddr_d = '0;
        end
      end
      RD_READ: begin
        if (rd_last) begin
          raddr_d = '0;
          if (!full_d[~rbank_q]) state_d = RD_IDLE;
        end else begin
          raddr_d = raddr_q + 1'b1;
        end
      end
      default: state_d = RD_IDLE;
    endcase

    vld_pipe_d = {vld_pipe_q[0], state_q == RD_READ};
    cnt_s1_d   = raddr_q;
    cnt_o_d    = vld_pipe_q[0] ? cnt_s1_q : cnt_o_q;
    z_re_d     = vld_pipe_q[0] ? ram_rdata[DW-1:DATA_WIDTH] : z_re_q;
    z_im_d     = vld_pipe_q[0] ? ram_rdata[DATA_WIDTH-1:0] : z_im_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state_q    <= RD_IDLE;
      raddr_q    <= '0;
      wbank_q    <= 1'b0;
      rbank_q    <= 1'b0;
      full_q     <= '0;
      overrun_q  <= 1'b0;
      vld_pipe_q <= '0;
      cnt_s1_q   <= '0;
      cnt_o_q    <= '0;
      z_re_q     <= '0;
      z_im_q     <= '0;
    end else begin
      state_q    <= state_d;
      raddr_q    <= raddr_d;
      wbank_q    <= wbank_d;
      rbank_q    <= rbank_d;
      full_q     <= full_d;
      overrun_q  <= overrun_d;
      vld_pipe_q <= vld_pipe_d;
      cnt_s1_q   <= cnt_s1_d;
      cnt_o_q    <= cnt_o_d;
      z_re_q     <= z_re_d;
      z_im_q     <= z_im_d;
    end
  end

  assign valid_o   = vld_pipe_q[1];
  assign cnt_o     = cnt_o_q;
  assign z_re_o    = z_re_q;
  assign z_im_o    = z_im_q;
  assign overrun_o = overrun_q;

endmodule

// File: tb/tb_fft_bit_reverse.sv
// Randomized bench for fft_bit_reverse: N=16 scenarios plus one full-size N=1024 frame.
module tb_fft_bit_reverse;

  localparam int DW = 25;
  localparam int NA = 16;
  localparam int LA = 4;
  localparam int NB = 1024;
  localparam int LB = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic                 a_vi, a_vo, a_ov;
  logic [LA-1:0]        a_ci, a_co;
  logic signed [DW-1:0] a_xr, a_xi, a_zr, a_zi;

  logic                 b_vi, b_vo, b_ov;
  logic [LB-1:0]        b_ci, b_co;
  logic signed [DW-1:0] b_xr, b_xi, b_zr, b_zi;

  fft_bit_reverse #(.DATA_WIDTH(DW), .FFT_N(NA), .FFT_NLOG2(LA)) dut_a (
    .clk_i(clk), .rst_n(rst_n), .valid_i(a_vi), .cnt_i(a_ci), .x_re_i(a_xr), .x_im_i(a_xi),
    .valid_o(a_vo), .cnt_o(a_co), .z_re_o(a_zr), .z_im_o(a_zi), .overrun_o(a_ov));

  fft_bit_reverse dut_b (
    .clk_i(clk), .rst_n(rst_n), .valid_i(b_vi), .cnt_i(b_ci), .x_re_i(b_xr), .x_im_i(b_xi),
    .valid_o(b_vo), .cnt_o(b_co), .z_re_o(b_zr), .z_im_o(b_zi), .overrun_o(b_ov));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int oq_cnt[$], oq_re[$], oq_im[$], oq_t[$];
  int bq_cnt[$], bq_re[$], bq_im[$];

  function automatic int brev(input int v, input int nb);
    int r = 0;
    for (int i = 0; i < nb; i++) if (((v >> i) & 1) != 0) r |= 1 << (nb - 1 - i);
    return r;
  endfunction

  function automatic int rnd25();
    return int'($urandom) >>> 7;
  endfunction

  task automatic step_a(input logic v, input int c, input int re, input int im);
    a_vi = v; a_ci = LA'(c); a_xr = DW'(re); a_xi = DW'(im);
    @(posedge clk); #1; cyc++;
    if (a_vo) begin
      oq_cnt.push_back(int'(a_co)); oq_re.push_back(int'(a_zr));
      oq_im.push_back(int'(a_zi)); oq_t.push_back(cyc);
    end
  endtask

  task automatic step_b(input logic v, input int c, input int re, input int im);
    b_vi = v; b_ci = LB'(c); b_xr = DW'(re); b_xi = DW'(im);
    @(posedge clk); #1; cyc++;
    if (b_vo) begin
      bq_cnt.push_back(int'(b_co)); bq_re.push_back(int'(b_zr)); bq_im.push_back(int'(b_zi));
    end
  endtask

  task automatic clear_q();
    oq_cnt.delete(); oq_re.delete(); oq_im.delete(); oq_t.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step_a(0, 0, 0, 0);
    step_a(0, 0, 0, 0);
    total++; if (a_vo !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", a_vo); end
    total++; if (a_co !== '0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", a_co); end
    total++; if (a_zr !== '0) begin bad++; $display("FAIL reset_zre got=%0d want=0", a_zr); end
    total++; if (a_zi !== '0) begin bad++; $display("FAIL reset_zim got=%0d want=0", a_zi); end
    total++; if (a_ov !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b want=0", a_ov); end
    total++; if (b_vo !== 1'b0 || b_ov !== 1'b0) begin bad++; $display("FAIL reset_b got=%b%b want=00", b_vo, b_ov); end
    rst_n = 1'b1;
    step_a(0, 0, 0, 0);
  endtask

  task automatic test_single();
    int t_end;
    clear_q();
    for (int c = 0; c < NA; c++) step_a(1, c, brev(c, LA), -brev(c, LA));
    t_end = cyc;
    repeat (20) step_a(0, 0, 0, 0);
    total++; if (oq_cnt.size() != NA) begin bad++; $display("FAIL single_count got=%0d want=%0d", oq_cnt.size(), NA); end
    for (int k = 0; k < NA && k < oq_cnt.size(); k++) begin
      total++; if (oq_cnt[k] != k) begin bad++; $display("FAIL single_cnt[%0d] got=%0d want=%0d", k, oq_cnt[k], k); end
      total++; if (oq_re[k] != k) begin bad++; $display("FAIL single_re[%0d] got=%0d want=%0d", k, oq_re[k], k); end
      total++; if (oq_im[k] != -k) begin bad++; $display("FAIL single_im[%0d] got=%0d want=%0d", k, oq_im[k], -k); end
      total++; if (oq_t[k] != t_end + 2 + k) begin bad++; $display("FAIL single_time[%0d] got=%0d want=%0d", k, oq_t[k], t_end + 2 + k); end
    end
  endtask

  task automatic test_back_to_back();
    int ir[48], ii[48];
    int t0 = 0;
    int f, k, src;
    clear_q();
    for (int n = 0; n < 48; n++) begin
      ir[n] = rnd25(); ii[n] = rnd25();
      step_a(1, n % NA, ir[n], ii[n]);
      if (n == NA - 1) t0 = cyc;
    end
    repeat (40) step_a(0, 0, 0, 0);
    total++; if (oq_cnt.size() != 48) begin bad++; $display("FAIL b2b_count got=%0d want=48", oq_cnt.size()); end
    for (int j = 0; j < 48 && j < oq_cnt.size(); j++) begin
      f = j / NA; k = j % NA; src = f * NA + brev(k, LA);
      total++; if (oq_cnt[j] != k) begin bad++; $display("FAIL b2b_cnt[%0d] got=%0d want=%0d", j, oq_cnt[j], k); end
      total++; if (oq_re[j] != ir[src] || oq_im[j] != ii[src]) begin
        bad++; $display("FAIL b2b_data[%0d] got=%0d,%0d want=%0d,%0d", j, oq_re[j], oq_im[j], ir[src], ii[src]); end
      total++; if (oq_t[j] != t0 + 2 + j) begin bad++; $display("FAIL b2b_time[%0d] got=%0d want=%0d", j, oq_t[j], t0 + 2 + j); end
    end
    total++; if (a_ov !== 1'b0) begin bad++; $display("FAIL b2b_overrun got=%b want=0", a_ov); end
  endtask

  task automatic test_gapped();
    int ir[NA], ii[NA];
    int t_end = 0;
    clear_q();
    for (int i = 0; i < 2 * NA; i++) begin
      if (i % 2 == 0) begin
        ir[i/2] = rnd25(); ii[i/2] = rnd25();
        step_a(1, i / 2, ir[i/2], ii[i/2]);
        if (i / 2 == NA - 1) t_end = cyc;
      end else begin
        step_a(0, int'($urandom_range(NA - 1)), rnd25(), rnd25());
      end
    end
    repeat (20) step_a(0, 0, 0, 0);
    total++; if (oq_cnt.size() != NA) begin bad++; $display("FAIL gap_count got=%0d want=%0d", oq_cnt.size(), NA); end
    for (int k = 0; k < NA && k < oq_cnt.size(); k++) begin
      total++; if (oq_cnt[k] != k) begin bad++; $display("FAIL gap_cnt[%0d] got=%0d want=%0d", k, oq_cnt[k], k); end
      total++; if (oq_re[k] != ir[brev(k, LA)] || oq_im[k] != ii[brev(k, LA)]) begin
        bad++; $display("FAIL gap_data[%0d] got=%0d,%0d want=%0d,%0d", k, oq_re[k], oq_im[k], ir[brev(k, LA)], ii[brev(k, LA)]); end
      total++; if (oq_t[k] != t_end + 2 + k) begin bad++; $display("FAIL gap_time[%0d] got=%0d want=%0d", k, oq_t[k], t_end + 2 + k); end
    end
  endtask

  task automatic test_overrun();
    for (int c = 0; c < NA; c++) step_a(1, c, rnd25(), rnd25());
    repeat (3) step_a(0, 0, 0, 0);
    total++; if (a_ov !== 1'b0) begin bad++; $display("FAIL ovr_before got=%b want=0", a_ov); end
    step_a(1, NA - 1, rnd25(), rnd25());
    step_a(1, NA - 1, rnd25(), rnd25());
    step_a(0, 0, 0, 0);
    total++; if (a_ov !== 1'b1) begin bad++; $display("FAIL ovr_rise got=%b want=1", a_ov); end
    for (int n = 0; n < 6; n++) begin
      repeat (10) step_a(0, 0, 0, 0);
      total++; if (a_ov !== 1'b1) begin bad++; $display("FAIL ovr_sticky[%0d] got=%b want=1", n, a_ov); end
    end
  endtask

  task automatic test_reset_mid();
    int ir[NA], ii[NA];
    int t_end, guard;
    logic hit;
    rst_n = 1'b0; step_a(0, 0, 0, 0); rst_n = 1'b1;
    total++; if (a_ov !== 1'b0) begin bad++; $display("FAIL mid_ovr_clear got=%b want=0", a_ov); end
    clear_q();
    for (int c = 0; c < NA; c++) step_a(1, c, rnd25(), rnd25());
    hit = 1'b0; guard = 0;
    while (!hit && guard < 40) begin
      step_a(0, 0, 0, 0);
      guard++;
      if (a_vo === 1'b1 && a_co == LA'(7)) hit = 1'b1;
    end
    total++; if (!hit) begin bad++; $display("FAIL mid_bin7_timeout got=%0d cycles want=bin7 seen", guard); end
    rst_n = 1'b0; step_a(0, 0, 0, 0); rst_n = 1'b1;
    total++; if (a_vo !== 1'b0) begin bad++; $display("FAIL mid_valid got=%b want=0", a_vo); end
    total++; if (a_co !== '0) begin bad++; $display("FAIL mid_cnt got=%0d want=0", a_co); end
    total++; if (a_zr !== '0 || a_zi !== '0) begin bad++; $display("FAIL mid_z got=%0d,%0d want=0,0", a_zr, a_zi); end
    clear_q();
    repeat (10) step_a(0, 0, 0, 0);
    total++; if (oq_cnt.size() != 0) begin bad++; $display("FAIL mid_discard got=%0d bins want=0", oq_cnt.size()); end
    clear_q();
    for (int c = 0; c < NA; c++) begin
      ir[c] = rnd25(); ii[c] = rnd25();
      step_a(1, c, ir[c], ii[c]);
    end
    t_end = cyc;
    repeat (20) step_a(0, 0, 0, 0);
    total++; if (oq_cnt.size() != NA) begin bad++; $display("FAIL fresh_count got=%0d want=%0d", oq_cnt.size(), NA); end
    for (int k = 0; k < NA && k < oq_cnt.size(); k++) begin
      total++; if (oq_cnt[k] != k || oq_t[k] != t_end + 2 + k) begin
        bad++; $display("FAIL fresh_cnt[%0d] got=%0d@%0d want=%0d@%0d", k, oq_cnt[k], oq_t[k], k, t_end + 2 + k); end
      total++; if (oq_re[k] != ir[brev(k, LA)] || oq_im[k] != ii[brev(k, LA)]) begin
        bad++; $display("FAIL fresh_data[%0d] got=%0d,%0d want=%0d,%0d", k, oq_re[k], oq_im[k], ir[brev(k, LA)], ii[brev(k, LA)]); end
    end
  endtask

  task automatic test_random_1024();
    int ir[NB], ii[NB];
    int src;
    bq_cnt.delete(); bq_re.delete(); bq_im.delete();
    for (int c = 0; c < NB; c++) begin
      ir[c] = rnd25(); ii[c] = rnd25();
      step_b(1, c, ir[c], ii[c]);
    end
    repeat (NB + 20) step_b(0, 0, 0, 0);
    total++; if (bq_cnt.size() != NB) begin bad++; $display("FAIL big_count got=%0d want=%0d", bq_cnt.size(), NB); end
    for (int k = 0; k < NB && k < bq_cnt.size(); k++) begin
      src = brev(k, LB);
      total++; if (bq_cnt[k] != k || bq_re[k] != ir[src] || bq_im[k] != ii[src]) begin
        bad++; $display("FAIL big_bin[%0d] got=%0d:%0d,%0d want=%0d:%0d,%0d", k, bq_cnt[k], bq_re[k], bq_im[k], k, ir[src], ii[src]); end
    end
    total++; if (b_ov !== 1'b0) begin bad++; $display("FAIL big_overrun got=%b want=0", b_ov); end
  endtask

  initial begin
    rst_n = 1'b0;
    a_vi = 1'b0; a_ci = '0; a_xr = '0; a_xi = '0;
    b_vi = 1'b0; b_ci = '0; b_xr = '0; b_xi = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_gapped();
    test_overrun();
    test_reset_mid();
    test_random_1024();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fft_bit_reverse.md
Name: fft_bit_reverse

Overview:
- Output reorder stage directly downstream of the last radix-2^2 butterfly stage of the streaming SDF FFT.
- The final butterfly stage emits bins in bit-reversed order, tagged with its running index counter. This block writes each sample into a ping-pong buffer at the bit-reversed address.
- It reads the completed frame back in natural frequency order, one bin per clock, tagged with the bin index, for the downstream magnitude/packing logic.

Parameters:
- DATA_WIDTH, 25, width of each real/imag sample (two's complement).
- FFT_N, 1024, points per frame; power of 4.
- FFT_NLOG2, 10, log2(FFT_N); sets index and address width.

Ports:
- clk_i  in  1  system clock, all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- valid_i  in  1  sample on x_*_i / cnt_i is valid this cycle.
- cnt_i  in  FFT_NLOG2  running index from last butterfly stage (position of sample in bit-reversed output stream).
- x_re_i  in  DATA_WIDTH signed  real part.
- x_im_i  in  DATA_WIDTH signed  imaginary part.
- valid_o  out  1  z_*_o / cnt_o carry a valid bin.
- cnt_o  out  FFT_NLOG2  natural-order bin index of current output.
- z_re_o  out  DATA_WIDTH signed  real part, natural order.
- z_im_o  out  DATA_WIDTH signed  imaginary part, natural order.
- overrun_o  out  1  sticky: a frame completed into a bank not yet read out.

Behaviour:
- Reset (rst_n low at a rising edge): valid_o=0, cnt_o=0, z_re_o=0, z_im_o=0, overrun_o=0.
  - Write bank = 0, read idle, both bank-full flags cleared.
  - RAM contents are not cleared.
  - Reset mid-frame discards the partial frame and any in-progress readout; valid_o is low on the cycle after the reset edge.
- Storage: 2 banks x FFT_N entries of {re,im} (2*DATA_WIDTH bits); simple dual-port with registered read.
- Write side:
  - Each cycle with valid_i=1, write {x_re_i,x_im_i} to address {wbank, bitrev(cnt_i)}. bitrev reverses all FFT_NLOG2 bits.
  - No internal write counter; frame position is taken from cnt_i only.
  - Frame completes on a cycle with valid_i=1 and cnt_i=FFT_N-1: set full[wbank], toggle wbank on the same edge.
  - If full[new wbank] is still set when the toggle happens, set overrun_o; the writer still overwrites that bank.
  - Skipped cnt_i values leave stale entries; no error is flagged.
- Read FSM:
  - IDLE: if any full[] is set, go to READ on rbank = oldest full bank (tracked as rbank register toggling per readout), raddr=0.
  - READ: issue raddr each cycle. After raddr=FFT_N-1, clear full[rbank], toggle rbank. If the other bank is already full, continue READ with raddr=0 on the next cycle (back-to-back, no bubble); otherwise go to IDLE.
- Latency: bin 0 is presented (valid_o=1, cnt_o=0) two clock edges after the edge that captured the cnt_i=FFT_N-1 sample.
  - Bins 0..FFT_N-1 then appear on consecutive cycles with cnt_o incrementing by 1 and wrapping to 0 for a back-to-back frame.
- Pipeline: raddr/rvalid register -> RAM read register -> output register. valid_o and cnt_o are delayed to stay aligned with data.
- Outputs hold their last value when valid_o=0.
- Simultaneous events:
  - A frame completing on the same edge as the readout's final address is not an overrun. The full flag is set and the readout continues seamlessly.
  - A write and a read to the same bank in one cycle cannot occur without overrun; if it does, read-during-write returns old data.
- Throughput: 1 sample/clock sustained, indefinitely, without overrun.

Decomposition:
- Shared fft package: function bitrev(index, FFT_NLOG2) and localparam ADDR_W=FFT_NLOG2+1. Reuse the package's existing FFT_N/FFT_NLOG2 constants.
- One sub-module, fft_bit_reverse_ram: simple dual-port RAM, depth 2*FFT_N, width 2*DATA_WIDTH, registered read, inferable as block RAM.
- Bank/full-flag logic and read FSM stay in the top module.

Test Plan (FFT_N=16, FFT_NLOG2=4 unless noted):
- Single frame, valid_i held high, cnt_i 0..15, x_re_i=bitrev(cnt_i), x_im_i=-bitrev(cnt_i) -> valid_o high 16 cycles starting two edges after cnt_i=15; z_re_o=cnt_o=0..15, z_im_o=-cnt_o.
- Three frames back-to-back continuous -> valid_o never drops across 48 bins, cnt_o wraps 15->0, overrun_o stays 0.
- Frame with valid_i toggling every other cycle (32 input cycles) -> output still 16 contiguous bins, same data mapping as the single-frame case.
- cnt_i jumps 15->15 twice within 2 cycles during readout (forced early completions) -> overrun_o rises and stays 1 until reset.
- Assert rst_n low at bin 7 of readout -> valid_o=0, cnt_o=0, z_*=0 the next cycle. A fresh frame after reset reads out correctly from bin 0.
- Default parameters (N=1024), random complex data -> output equals software bit-reverse permutation of input, bin for bin.
